// File: rtl/fifo_drain_pkg.sv
// Shared types and helpers for the FIFO read-drain block.
// The occupancy type covers the 2-entry skid buffer. next_beat() wraps the
// burst beat counter back to zero.
package fifo_drain_pkg;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_MAX = 2'd2;

  function automatic logic [31:0] next_beat(input logic [31:0] beat,
                                            input logic [31:0] burst_len);
    logic [31:0] result;
    if (beat >= (burst_len - 32'd1)) begin
      result = 32'd0;
    end else begin
      result = beat + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_drain_skid.sv
// Two-entry buffer that sits between the FIFO read port and the output stream.
// The head entry always drives the outgoing data. A push and a pop in the same
// cycle keep the occupancy unchanged. When that happens with a single entry
// held, the pushed word becomes the new head.
module fifo_drain_skid
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output occ_t                  cnt,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] tail_data;
  logic                  do_push;
  logic                  do_pop;

  // Qualify requests so the buffer can never overflow or underflow.
  always_comb begin
    do_push = push & ((cnt != OCC_MAX) | pop);
    do_pop  = pop & (cnt != 2'd0);
  end

  // Occupancy and storage update; head only moves on pop or when filling an empty buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 2'd0;
      head_data <= '0;
      tail_data <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) begin
            head_data <= push_data;
          end else begin
            tail_data <= push_data;
          end
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          cnt       <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            head_data <= push_data;
          end else begin
            head_data <= tail_data;
            tail_data <= push_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/fifo_read_drain.sv
// Drains a synchronous FIFO with a one-cycle registered read. The drained words
// are re-presented as a valid/ready stream framed into fixed-length bursts.
// A read is only issued when the skid buffer has room for its returning word,
// even if the current beat is not accepted.
// Optional feature: define FIFO_DRAIN_WORD_CNT_EN to add a saturating
// accepted-beat counter on the word_count port.
module fifo_read_drain
  import fifo_drain_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef FIFO_DRAIN_WORD_CNT_EN
  ,
  output logic [31:0]           word_count
`endif
);

  localparam logic [31:0] BURST_LEN_W = 32'(BURST_LEN);
  localparam logic [31:0] LAST_BEAT   = 32'(BURST_LEN - 1);

  occ_t        cnt;
  logic        rd_pend;
  logic        pop;
  logic [2:0]  committed;
  logic [31:0] beat_cnt;

  // Stream handshake and read credit.
  // committed counts the words that will occupy the buffer after this edge.
  always_comb begin
    m_valid   = (cnt != 2'd0);
    pop       = m_valid & m_ready;
    committed = {1'b0, cnt} + {2'b00, rd_pend} - {2'b00, pop};
    fifo_r_en = ~fifo_empty & ~rst & (committed <= 3'd1);
    m_last    = m_valid & (beat_cnt == LAST_BEAT);
  end

  // Track the read in flight so its data is captured exactly one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= fifo_r_en;
    end
  end

  // Beat position within the burst; held while the stream is stalled or empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= 32'd0;
    end else if (pop) begin
      beat_cnt <= next_beat(beat_cnt, BURST_LEN_W);
    end
  end

`ifdef FIFO_DRAIN_WORD_CNT_EN
  // Saturating count of accepted beats, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count <= 32'd0;
    end else if (pop && (word_count != 32'hFFFF_FFFF)) begin
      word_count <= word_count + 32'd1;
    end
  end
`endif

  fifo_drain_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_pend),
    .push_data(fifo_data),
    .pop      (pop),
    .cnt      (cnt),
    .head_data(m_data)
  );

endmodule

// File: tb/tb_fifo_read_drain.sv
// Self-checking bench for fifo_read_drain.
// The bench holds a queue-based FIFO with a one-cycle registered read. A
// scoreboard model follows the words taken from that FIFO, the beats accepted
// downstream and the burst position. Define FIFO_DRAIN_WORD_CNT_EN to also
// exercise word_count.
module tb_fifo_read_drain;

  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_r_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
`ifdef FIFO_DRAIN_WORD_CNT_EN
  logic [31:0]   word_count;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] sb[$];
  logic [DW:0]   acc_log[$];
  bit            model_ok   = 1'b0;
  bit            just_reset = 1'b0;
  bit            pend_valid = 1'b0;
  logic [DW-1:0] pend_word  = '0;
  int            beats      = 0;
  logic [31:0]   model_wc   = 32'd0;

  fifo_read_drain #(
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_r_en (fifo_r_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
`ifdef FIFO_DRAIN_WORD_CNT_EN
    ,
    .word_count(word_count)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic apply_stimulus(input logic r, input logic rdy);
    rst     = r;
    m_ready = rdy;
  endtask

  // FIFO read port: data appears one clock after the read enable.
  always @(posedge clk) begin
    if (fifo_r_en && (fifo_q.size() > 0)) begin
      fifo_data  <= fifo_q.pop_front();
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Scoreboard: compares every cycle, then advances the model across the coming edge.
  always @(negedge clk) begin : monitor
    bit exp_valid;
    bit exp_pop;
    bit exp_ren;
    int occ;
    exp_valid = (sb.size() != 0);
    exp_pop   = exp_valid && (m_ready === 1'b1);
    check_output("r_en_while_empty", {31'd0, fifo_r_en & fifo_empty}, 32'd0);
    if (rst) check_output("r_en_in_reset", {31'd0, fifo_r_en}, 32'd0);
    if (model_ok) begin
      check_output("m_valid", {31'd0, m_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
        check_output("m_data", {24'd0, m_data}, {24'd0, sb[0]});
        check_output("m_last", {31'd0, m_last}, {31'd0, ((beats % BL) == (BL - 1))});
      end else begin
        check_output("m_last_idle", {31'd0, m_last}, 32'd0);
      end
      if (just_reset) check_output("m_data_reset", {24'd0, m_data}, 32'd0);
      occ     = sb.size() + int'(pend_valid) - int'(exp_pop);
      exp_ren = !fifo_empty && !rst && (occ <= 1);
      check_output("fifo_r_en", {31'd0, fifo_r_en}, {31'd0, exp_ren});
`ifdef FIFO_DRAIN_WORD_CNT_EN
      check_output("word_count", word_count, model_wc);
`endif
    end else begin
      exp_ren = 1'b0;
    end
    if (rst) begin
      sb.delete();
      pend_valid = 1'b0;
      beats      = 0;
      model_wc   = 32'd0;
      model_ok   = 1'b1;
      just_reset = 1'b1;
    end else if (model_ok) begin
      just_reset = 1'b0;
      if (exp_pop) begin
        acc_log.push_back({m_last, m_data});
        void'(sb.pop_front());
        beats++;
        if (model_wc != 32'hFFFF_FFFF) model_wc = model_wc + 32'd1;
      end
      if (pend_valid) sb.push_back(pend_word);
      pend_valid = exp_ren && (fifo_q.size() > 0);
      if (pend_valid) pend_word = fifo_q[0];
    end
  end

  initial begin
    logic [DW-1:0] exp_words[$];
    logic [DW-1:0] w;
    logic [DW-1:0] held;
    int            base;
    bit            exp_v;

    $display("[TB] fifo_read_drain bench start");
    fifo_empty = 1'b1;
    fifo_data  = 8'hEE;
    apply_stimulus(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) push_word(8'h10 + 8'(i));

    // Reset held for two clocks with the FIFO non-empty.
    @(negedge clk);
    check_output("reset_r_en_a", {31'd0, fifo_r_en}, 32'd0);
    next_cycle();
    @(negedge clk);
    check_output("reset_r_en_b", {31'd0, fifo_r_en}, 32'd0);
    check_output("reset_valid", {31'd0, m_valid}, 32'd0);
    check_output("reset_data", {24'd0, m_data}, 32'd0);
    check_output("reset_last", {31'd0, m_last}, 32'd0);
    next_cycle();
    apply_stimulus(1'b0, 1'b1);
    @(negedge clk);
    check_output("first_r_en", {31'd0, fifo_r_en}, 32'd1);
    check_output("first_valid", {31'd0, m_valid}, 32'd0);

    // Full-rate stream of 8'h10..8'h17.
    for (int i = 1; i <= 10; i++) begin
      next_cycle();
      @(negedge clk);
      exp_v = (i >= 2) && (i <= 9);
      check_output("stream_valid", {31'd0, m_valid}, {31'd0, exp_v});
      if (exp_v) begin
        check_output("stream_data", {24'd0, m_data}, 32'h10 + 32'(i - 2));
        check_output("stream_last", {31'd0, m_last}, {31'd0, ((i == 5) || (i == 9))});
      end
    end

    // Backpressure mid-stream.
    next_cycle();
    acc_log.delete();
    for (int i = 0; i < 8; i++) push_word(8'h20 + 8'(i));
    run_cycles(3);
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      held = m_data;
      check_output("bp_valid", {31'd0, m_valid}, 32'd1);
      check_output("bp_hold", {24'd0, held}, 32'h21);
      if (k >= 1) check_output("bp_r_en_off", {31'd0, fifo_r_en}, 32'd0);
      next_cycle();
    end
    m_ready = 1'b1;
    run_cycles(10);
    check_output("bp_count", acc_log.size(), 32'd8);
    for (int j = 0; j < 8; j++) begin
      if (acc_log.size() > j)
        check_output("bp_beat", {23'd0, acc_log[j]}, {23'd0, ((j % BL) == (BL - 1)), 8'h20 + 8'(j)});
    end

    // FIFO runs dry mid-burst, then refills to finish the burst.
    acc_log.delete();
    push_word(8'h30);
    push_word(8'h31);
    run_cycles(6);
    @(negedge clk);
    check_output("gap_valid_low", {31'd0, m_valid}, 32'd0);
    next_cycle();
    push_word(8'hA0);
    push_word(8'hA1);
    run_cycles(6);
    check_output("gap_count", acc_log.size(), 32'd4);
    if (acc_log.size() == 4) begin
      check_output("gap_b0", {23'd0, acc_log[0]}, {23'd0, 9'h030});
      check_output("gap_b1", {23'd0, acc_log[1]}, {23'd0, 9'h031});
      check_output("gap_b2", {23'd0, acc_log[2]}, {23'd0, 9'h0A0});
      check_output("gap_b3", {23'd0, acc_log[3]}, {23'd0, 9'h1A1});
    end

    // Reset arriving while a read is in flight.
    push_word(8'h55);
    @(negedge clk);
    check_output("mf_r_en", {31'd0, fifo_r_en}, 32'd1);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_output("mf_valid", {31'd0, m_valid}, 32'd0);
      check_output("mf_data", {24'd0, m_data}, 32'd0);
      check_output("mf_last", {31'd0, m_last}, 32'd0);
      next_cycle();
    end

    // Twenty accepted beats, then saturation of the optional counter.
    acc_log.delete();
    for (int i = 0; i < 20; i++) push_word(8'h40 + 8'(i));
    run_cycles(26);
    check_output("wc_beats", acc_log.size(), 32'd20);
`ifdef FIFO_DRAIN_WORD_CNT_EN
    check_output("wc_twenty", word_count, 32'd20);
    force dut.word_count = 32'hFFFF_FFFE;
    model_wc = 32'hFFFF_FFFE;
    #1;
    release dut.word_count;
    for (int i = 0; i < 3; i++) push_word(8'h60 + 8'(i));
    run_cycles(8);
    check_output("wc_saturate", word_count, 32'hFFFF_FFFF);
`endif

    // Random traffic with random backpressure, checked end to end.
    acc_log.delete();
    exp_words.delete();
    base = beats;
    for (int c = 0; c < 400; c++) begin
      if ((($urandom % 3) != 0) && (fifo_q.size() < 8)) begin
        w = 8'($urandom);
        push_word(w);
        exp_words.push_back(w);
      end
      m_ready = (c < 200) ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
      next_cycle();
    end
    m_ready = 1'b1;
    run_cycles(20);
    check_output("rand_count", acc_log.size(), exp_words.size());
    for (int j = 0; j < exp_words.size(); j++) begin
      if (acc_log.size() > j)
        check_output("rand_beat", {23'd0, acc_log[j]},
                     {23'd0, (((base + j) % BL) == (BL - 1)), exp_words[j]});
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
